// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter and address/access sequencer
module bus_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_REQ       = 4,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic [ADDRESS_WIDTH-1:0]           bus_address,
    output logic                               bus_address_read_enable,
    output logic                               bus_enable,
    output logic                               bus_write,
    output logic [DATA_WIDTH-1:0]              bus_wdata,
    input  logic [DATA_WIDTH-1:0]              bus_rdata
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           own_idx;
    logic [PW-1:0]           win_idx;
    logic                    win_valid;
    logic [3:0]              cnt;
    logic                    cap_write;
    logic [DATA_WIDTH-1:0]   cap_wdata;

    // Walk downward so the lowest offset from ptr is the final assignment.
    always_comb begin
        int j;
        win_valid = 1'b0;
        win_idx   = ptr;
        j         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                win_valid = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (win_valid) state_nxt = S_ADDR;
            S_ADDR:   state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // bus_address doubles as the captured address so it is stable for all of ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            own_idx     <= '0;
            grant       <= '0;
            rdata       <= '0;
            bus_address <= '0;
            cap_write   <= 1'b0;
            cap_wdata   <= '0;
            cnt         <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        own_idx     <= win_idx;
                        cap_write   <= req_write[win_idx];
                        bus_address <= req_address[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        cap_wdata   <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_ADDR: begin
                    cnt <= 4'(WAIT_CYCLES - 1);
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!cap_write) begin
                            rdata <= bus_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    grant <= '0;
                    ptr   <= (own_idx == PW'(NUM_REQ - 1)) ? '0 : own_idx + 1'b1;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    assign bus_address_read_enable = (state == S_ADDR);
    assign bus_enable              = (state == S_ACCESS);
    assign bus_write               = (state == S_ACCESS) && cap_write;
    assign bus_wdata               = cap_wdata;
    assign ack                     = (state == S_DONE) ? grant : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with one- and three-cycle access
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst1;
    logic        rst3;
    logic [3:0]  req;
    logic [3:0]  req_write;
    logic [63:0] req_address;
    logic [31:0] req_wdata;
    logic [7:0]  bus_rdata;

    logic [3:0]  grant1, ack1, grant3, ack3;
    logic [7:0]  rdata1, rdata3, wdata1, wdata3;
    logic [15:0] addr1, addr3;
    logic        are1, en1, wr1, are3, en3, wr3;

    int sel;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(16), .NUM_REQ(4), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .req(req), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .grant(grant1), .ack(ack1), .rdata(rdata1), .bus_address(addr1),
        .bus_address_read_enable(are1), .bus_enable(en1), .bus_write(wr1),
        .bus_wdata(wdata1), .bus_rdata(bus_rdata)
    );

    bus_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(16), .NUM_REQ(4), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .req(req), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .grant(grant3), .ack(ack3), .rdata(rdata3), .bus_address(addr3),
        .bus_address_read_enable(are3), .bus_enable(en3), .bus_write(wr3),
        .bus_wdata(wdata3), .bus_rdata(bus_rdata)
    );

    wire [3:0]  o_grant = (sel != 0) ? grant3 : grant1;
    wire [3:0]  o_ack   = (sel != 0) ? ack3   : ack1;
    wire [7:0]  o_rdata = (sel != 0) ? rdata3 : rdata1;
    wire [7:0]  o_wdata = (sel != 0) ? wdata3 : wdata1;
    wire [15:0] o_addr  = (sel != 0) ? addr3  : addr1;
    wire        o_are   = (sel != 0) ? are3   : are1;
    wire        o_en    = (sel != 0) ? en3    : en1;
    wire        o_wr    = (sel != 0) ? wr3    : wr1;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_rd[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_ack != 4'b0) begin
            if (sb.size() == 0) begin
                check("ack_extra", {28'b0, o_ack}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_ack", {28'b0, o_ack}, {28'b0, mon_e.ack});
                check("sb_rdata", {24'b0, o_rdata}, {24'b0, mon_e.rd});
            end
        end
    end

    task automatic push_exp(input int idx, input logic wr, input logic [7:0] rdv);
        exp_t e;
        e.ack = 4'b0001 << idx;
        e.rd  = wr ? last_rd[sel] : rdv;
        last_rd[sel] = e.rd;
        sb.push_back(e);
    endtask

    // Entered #1 after a rising edge with the selected DUT in IDLE; returns likewise.
    task automatic run_one(input int idx, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] rdv, input logic withdraw);
        int w;
        logic [3:0] oh;
        w  = (sel != 0) ? 3 : 1;
        oh = 4'b0001 << idx;
        push_exp(idx, wr, rdv);
        req[idx] = 1'b1;
        req_write[idx] = wr;
        req_address[idx*16 +: 16] = addr;
        req_wdata[idx*8 +: 8] = wd;
        @(posedge clk); #1;
        check("addr_re", {31'b0, o_are}, 32'h1);
        check("addr_val", {16'b0, o_addr}, {16'b0, addr});
        check("addr_en", {31'b0, o_en}, 32'h0);
        check("addr_grant", {28'b0, o_grant}, {28'b0, oh});
        for (int k = 0; k < w; k++) begin
            @(posedge clk); #1;
            bus_rdata = (k == w - 1) ? rdv : ((k == 0) ? 8'h00 : 8'hFF);
            if (withdraw && k == 0) req[idx] = 1'b0;
            check("acc_en", {31'b0, o_en}, 32'h1);
            check("acc_wr", {31'b0, o_wr}, {31'b0, wr});
            check("acc_re", {31'b0, o_are}, 32'h0);
            check("acc_addr", {16'b0, o_addr}, {16'b0, addr});
            if (wr) check("acc_wdata", {24'b0, o_wdata}, {24'b0, wd});
        end
        @(posedge clk); #1;
        check("done_ack", {28'b0, o_ack}, {28'b0, oh});
        check("done_en", {31'b0, o_en}, 32'h0);
        check("done_wr", {31'b0, o_wr}, 32'h0);
        req[idx] = 1'b0;
        @(posedge clk); #1;
        check("idle_grant", {28'b0, o_grant}, 32'h0);
        check("idle_addr", {16'b0, o_addr}, {16'b0, addr});
    endtask

    task automatic wait_acks(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(posedge clk); #1;
            if (o_ack != 4'b0) seen++;
        end
        check("acks_seen", seen, n);
        req = 4'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        last_rd[0] = 8'h00;
    endtask

    initial begin
        int k;
        logic hit;
        sel = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        req = 4'b0;
        req_write = 4'b0;
        req_address = '0;
        req_wdata = '0;
        bus_rdata = 8'h00;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", {28'b0, o_grant}, 32'h0);
        check("rst_ack", {28'b0, o_ack}, 32'h0);
        check("rst_rdata", {24'b0, o_rdata}, 32'h0);
        check("rst_addr", {16'b0, o_addr}, 32'h0);
        check("rst_strobes", {29'b0, o_are, o_en, o_wr}, 32'h0);
        rst1 = 1'b0;

        // Reset mid-ACCESS abandons the transaction; it restarts from IDLE.
        req[0] = 1'b1;
        req_address[15:0] = 16'h0042;
        bus_rdata = 8'h33;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_en", {31'b0, o_en}, 32'h1);
        reset1();
        check("mid_rst_grant", {28'b0, o_grant}, 32'h0);
        check("mid_rst_ack", {28'b0, o_ack}, 32'h0);
        check("mid_rst_en", {31'b0, o_en}, 32'h0);
        push_exp(0, 1'b0, 8'h33);
        k = 0;
        hit = 1'b0;
        for (int c = 1; c <= 20 && !hit; c++) begin
            @(posedge clk); #1;
            if (o_ack != 4'b0) begin
                hit = 1'b1;
                k = c;
            end
        end
        check("rst_restart_lat", k, 3);
        req[0] = 1'b0;
        @(posedge clk); #1;

        run_one(2, 1'b0, 16'h8012, 8'h00, 8'h5A, 1'b0);
        run_one(1, 1'b1, 16'h0100, 8'hC3, 8'h77, 1'b0);
        run_one(0, 1'b0, 16'h2222, 8'h00, 8'h9E, 1'b1);
        @(posedge clk); #1;
        check("wd_idle_grant", {28'b0, o_grant}, 32'h0);
        check("wd_idle_re", {31'b0, o_are}, 32'h0);

        // Rotation from a fresh pointer, then the 4'b1001 wrap cases.
        reset1();
        bus_rdata = 8'hA0;
        req_write = 4'b0;
        req_address = 64'h4444_3333_2222_1111;
        push_exp(0, 1'b0, 8'hA0);
        push_exp(1, 1'b0, 8'hA0);
        push_exp(2, 1'b0, 8'hA0);
        push_exp(3, 1'b0, 8'hA0);
        push_exp(0, 1'b0, 8'hA0);
        req = 4'b1111;
        wait_acks(5);
        run_one(3, 1'b0, 16'h4444, 8'h00, 8'hA0, 1'b0);
        push_exp(0, 1'b0, 8'hA0);
        push_exp(3, 1'b0, 8'hA0);
        req = 4'b1001;
        wait_acks(2);

        // Three-cycle access instance.
        rst1 = 1'b1;
        sel = 1;
        rst3 = 1'b0;
        @(posedge clk); #1;
        run_one(0, 1'b0, 16'h1234, 8'h00, 8'h11, 1'b0);
        run_one(2, 1'b1, 16'hBEEF, 8'h5C, 8'h66, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
